// File: rtl/burst_memory.sv
// -----------------------------------------------------------------------------
// burst_memory
//   Single-port, single-clock word memory with burst write and burst read.
//   A command (write or read burst) is taken only while the block is idle.
//   A write stores one beat per cycle, starting on the command cycle. A read
//   returns one registered beat per cycle, starting the cycle after the command.
//   Burst addresses wrap from DEPTH-1 to 0. Memory contents are not cleared
//   by reset.
//
// Ports
//   Mem_CLK   in   1           clock, all logic on the rising edge
//   Mem_RST   in   1           synchronous active-high reset
//   Mem_RW    in   2           00 idle, 01 write burst, 10 read burst, 11 ignored
//   Mem_ADDR  in   ADDR_WIDTH  burst start address (command cycle only)
//   Mem_LEN   in   LEN_WIDTH   burst beats minus one (command cycle only)
//   Mem_IDR   in   DATA_WIDTH  write data, one beat per cycle
//   Mem_ODR   out  DATA_WIDTH  registered read data, held between beats
//   Mem_DRDY  out  1           read beat valid / write burst complete strobe
//   Mem_BUSY  out  1           burst in progress, commands ignored
//   Mem_ERR   out  1           one-cycle pulse on a rejected command
//
// Configuration macro
//   MEM_BOUNDS_CHECK_EN : when defined, a command whose address is >= DEPTH
//                         is rejected and Mem_ERR pulses the following cycle.
//                         When undefined, Mem_ERR is tied low and the address
//                         is truncated to the word index.
// -----------------------------------------------------------------------------
module burst_memory #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 262144,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  Mem_CLK,
  input  logic                  Mem_RST,
  input  logic [1:0]            Mem_RW,
  input  logic [ADDR_WIDTH-1:0] Mem_ADDR,
  input  logic [LEN_WIDTH-1:0]  Mem_LEN,
  input  logic [DATA_WIDTH-1:0] Mem_IDR,
  output logic [DATA_WIDTH-1:0] Mem_ODR,
  output logic                  Mem_DRDY,
  output logic                  Mem_BUSY,
  output logic                  Mem_ERR
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IDX_W-1:0]      addr_r;
  logic [IDX_W-1:0]      addr_nxt_s;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic [LEN_WIDTH-1:0]  rem_nxt_s;
  logic                  busy_r;
  logic                  busy_nxt_s;
  logic                  drdy_r;
  logic                  drdy_nxt_s;
  logic [DATA_WIDTH-1:0] odr_r;

  logic                  mem_we_s;
  logic                  rd_en_s;
  logic [IDX_W-1:0]      mem_addr_s;

  logic                  cmd_wr_s;
  logic                  cmd_rd_s;
  logic                  cmd_rej_s;
  logic [IDX_W-1:0]      cmd_idx_s;

  assign cmd_wr_s = (Mem_RW == 2'b01);
  assign cmd_rd_s = (Mem_RW == 2'b10);
  // DEPTH is a power of two, so the modulo is a plain truncation to the index.
  assign cmd_idx_s = IDX_W'(Mem_ADDR % DEPTH_A);

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_r;

  assign cmd_rej_s = (cmd_wr_s || cmd_rd_s) && (Mem_ADDR >= DEPTH_A);

  // Error strobe: one cycle after a rejected command seen while idle.
  always_ff @(posedge Mem_CLK) begin
    if (Mem_RST) begin
      err_r <= 1'b0;
    end else begin
      err_r <= cmd_rej_s && (state_r == ST_IDLE);
    end
  end

  assign Mem_ERR = err_r;
`else
  assign cmd_rej_s = 1'b0;
  assign Mem_ERR   = 1'b0;
`endif

  // Next-state and datapath control for the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    rem_nxt_s   = rem_r;
    busy_nxt_s  = busy_r;
    drdy_nxt_s  = 1'b0;
    mem_we_s    = 1'b0;
    rd_en_s     = 1'b0;
    mem_addr_s  = addr_r;

    case (state_r)
      ST_IDLE: begin
        mem_addr_s = cmd_idx_s;
        if (cmd_rej_s) begin
          // Rejected command: no access, the error strobe is raised elsewhere.
          state_nxt_s = ST_IDLE;
        end else if (cmd_wr_s) begin
          // Beat 0 lands on the command cycle itself.
          mem_we_s   = 1'b1;
          addr_nxt_s = cmd_idx_s + IDX_ONE;
          rem_nxt_s  = Mem_LEN;
          if (Mem_LEN == LEN_ZERO) begin
            drdy_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_WRITE;
            busy_nxt_s  = 1'b1;
          end
        end else if (cmd_rd_s) begin
          // Beat 0 is fetched now and presented next cycle.
          rd_en_s     = 1'b1;
          drdy_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_READ;
          addr_nxt_s  = cmd_idx_s + IDX_ONE;
          rem_nxt_s   = Mem_LEN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // rem_r counts beats still to store, including this one.
        mem_we_s   = 1'b1;
        addr_nxt_s = addr_r + IDX_ONE;
        rem_nxt_s  = rem_r - LEN_ONE;
        if (rem_r == LEN_ONE) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          drdy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end

      ST_READ: begin
        // rem_r counts beats still to fetch; BUSY stays up while the last
        // beat is on the output, then drops.
        if (rem_r != LEN_ZERO) begin
          rd_en_s    = 1'b1;
          drdy_nxt_s = 1'b1;
          addr_nxt_s = addr_r + IDX_ONE;
          rem_nxt_s  = rem_r - LEN_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge Mem_CLK) begin
    if (Mem_RST) begin
      state_r <= ST_IDLE;
      addr_r  <= IDX_ZERO;
      rem_r   <= LEN_ZERO;
      busy_r  <= 1'b0;
      drdy_r  <= 1'b0;
      odr_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      rem_r   <= rem_nxt_s;
      busy_r  <= busy_nxt_s;
      drdy_r  <= drdy_nxt_s;
      if (rd_en_s) begin
        odr_r <= mem_r[mem_addr_s];
      end
    end
  end

  // Word storage; deliberately not reset, and writes are blocked during reset.
  always_ff @(posedge Mem_CLK) begin
    if (mem_we_s && !Mem_RST) begin
      mem_r[mem_addr_s] <= Mem_IDR;
    end
  end

  assign Mem_ODR  = odr_r;
  assign Mem_DRDY = drdy_r;
  assign Mem_BUSY = busy_r;

endmodule

// File: tb/tb_burst_memory.sv
// -----------------------------------------------------------------------------
// tb_burst_memory
//   Directed bench for burst_memory (DEPTH reduced to 256). A table of
//   per-cycle vectors holds the inputs for cycle Tk and the outputs expected
//   in cycle Tk+1; hand-written sequences cover reset mid-burst and the
//   out-of-range address case.
// -----------------------------------------------------------------------------
module tb_burst_memory;

  localparam int DW    = 24;
  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int LW    = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    rw;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic [DW-1:0] idr;
  logic [DW-1:0] odr;
  logic          drdy;
  logic          busy;
  logic          err;

  int total;
  int bad;

  burst_memory #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .Mem_CLK (clk),
    .Mem_RST (rst),
    .Mem_RW  (rw),
    .Mem_ADDR(addr),
    .Mem_LEN (len),
    .Mem_IDR (idr),
    .Mem_ODR (odr),
    .Mem_DRDY(drdy),
    .Mem_BUSY(busy),
    .Mem_ERR (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] idr;
    logic          e_drdy;
    logic          e_busy;
    logic [DW-1:0] e_odr;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
  task automatic do_cycle(input logic r, input logic [1:0] c, input logic [AW-1:0] a,
                          input logic [LW-1:0] l, input logic [DW-1:0] d);
    rst  = r;
    rw   = c;
    addr = a;
    len  = l;
    idr  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [AW-1:0] a,
                              input logic [LW-1:0] l, input logic [DW-1:0] d,
                              input logic ed, input logic eb, input logic [DW-1:0] eo);
    vec_t v;
    v.rst = r; v.rw = c; v.addr = a; v.len = l; v.idr = d;
    v.e_drdy = ed; v.e_busy = eb; v.e_odr = eo;
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_mid_reset(input int k);
    if (k < 2) return DW'(32'hE00 + k);
    return DW'(32'h100 + k);
  endfunction

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst = 1'b1; rw = 2'b00; addr = '0; len = '0; idr = '0;

    //            rst   rw     addr          len    idr             drdy  busy  odr
    vecs[0]  = mk(1'b1, 2'b10, 32'd0,   4'd0, 24'h000000, 1'b0, 1'b0, 24'h000000);
    vecs[1]  = mk(1'b0, 2'b01, 32'd0,   4'd0, 24'hAABBCC, 1'b1, 1'b0, 24'h000000);
    vecs[2]  = mk(1'b0, 2'b10, 32'd0,   4'd0, 24'h000000, 1'b1, 1'b1, 24'hAABBCC);
    vecs[3]  = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b0, 1'b0, 24'hAABBCC);
    vecs[4]  = mk(1'b0, 2'b01, 32'd10,  4'd3, 24'h111111, 1'b0, 1'b1, 24'hAABBCC);
    vecs[5]  = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h222222, 1'b0, 1'b1, 24'hAABBCC);
    vecs[6]  = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h333333, 1'b0, 1'b1, 24'hAABBCC);
    vecs[7]  = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h444444, 1'b1, 1'b0, 24'hAABBCC);
    vecs[8]  = mk(1'b0, 2'b10, 32'd10,  4'd3, 24'h000000, 1'b1, 1'b1, 24'h111111);
    vecs[9]  = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b1, 1'b1, 24'h222222);
    vecs[10] = mk(1'b0, 2'b10, 32'd0,   4'd0, 24'h000000, 1'b1, 1'b1, 24'h333333);
    vecs[11] = mk(1'b0, 2'b01, 32'd0,   4'd0, 24'h999999, 1'b1, 1'b1, 24'h444444);
    vecs[12] = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b0, 1'b0, 24'h444444);
    vecs[13] = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b0, 1'b0, 24'h444444);
    vecs[14] = mk(1'b0, 2'b11, 32'd0,   4'd0, 24'h555555, 1'b0, 1'b0, 24'h444444);
    vecs[15] = mk(1'b0, 2'b01, 32'd255, 4'd1, 24'hAAAAAA, 1'b0, 1'b1, 24'h444444);
    vecs[16] = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'hBBBBBB, 1'b1, 1'b0, 24'h444444);
    vecs[17] = mk(1'b0, 2'b10, 32'd255, 4'd1, 24'h000000, 1'b1, 1'b1, 24'hAAAAAA);
    vecs[18] = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b1, 1'b1, 24'hBBBBBB);
    vecs[19] = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b0, 1'b0, 24'hBBBBBB);
    vecs[20] = mk(1'b0, 2'b10, 32'd0,   4'd0, 24'h000000, 1'b1, 1'b1, 24'hBBBBBB);
    vecs[21] = mk(1'b0, 2'b00, 32'd0,   4'd0, 24'h000000, 1'b0, 1'b0, 24'hBBBBBB);

    for (int i = 0; i < 22; i++) begin
      do_cycle(vecs[i].rst, vecs[i].rw, vecs[i].addr, vecs[i].len, vecs[i].idr);
      check($sformatf("vec%0d_drdy", i), {31'd0, drdy}, {31'd0, vecs[i].e_drdy});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("vec%0d_odr", i),  {8'd0, odr},   {8'd0, vecs[i].e_odr});
      check($sformatf("vec%0d_err", i),  {31'd0, err},  32'd0);
    end

    // Word 0 must still hold BBBBBB: the reserved command at vec14 and the
    // write issued while busy at vec11 were both ignored.
    do_cycle(1'b0, 2'b10, 32'd0, 4'd0, 24'd0);
    check("ignored_cmds_word0", {8'd0, odr}, {8'd0, 24'hBBBBBB});
    do_cycle(1'b0, 2'b00, 32'd0, 4'd0, 24'd0);

    // Reset in T2 of an 8-beat write: preload 20..27, then overwrite.
    for (int k = 0; k < 8; k++) begin
      do_cycle(1'b0, (k == 0) ? 2'b01 : 2'b00, 32'd20, 4'd7, DW'(32'h100 + k));
    end
    check("preload_drdy", {31'd0, drdy}, 32'd1);
    do_cycle(1'b0, 2'b00, 32'd0, 4'd0, 24'd0);
    do_cycle(1'b0, 2'b01, 32'd20, 4'd7, 24'hE00);
    do_cycle(1'b0, 2'b00, 32'd0,  4'd0, 24'hE01);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    do_cycle(1'b1, 2'b10, 32'd20, 4'd0, 24'hE02);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drdy", {31'd0, drdy}, 32'd0);
    check("rst_odr",  {8'd0, odr},   32'd0);
    for (int k = 3; k < 6; k++) begin
      do_cycle(1'b0, 2'b00, 32'd0, 4'd0, DW'(32'hE00 + k));
      check($sformatf("post_rst_quiet%0d", k), {30'd0, drdy, busy}, 32'd0);
    end

    do_cycle(1'b0, 2'b10, 32'd20, 4'd7, 24'd0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (drdy) begin
        check($sformatf("mid_rst_word%0d", 20 + n), {8'd0, odr}, {8'd0, exp_mid_reset(n)});
        n++;
      end
      do_cycle(1'b0, 2'b00, 32'd0, 4'd0, 24'd0);
    end
    check("mid_rst_beats", n, 32'd8);

    // Address DEPTH: rejected with bounds checking, else aliases word 0.
    do_cycle(1'b0, 2'b10, 32'd256, 4'd0, 24'd0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_err_t1",  {31'd0, err},  32'd1);
    check("oob_drdy_t1", {31'd0, drdy}, 32'd0);
    check("oob_busy_t1", {31'd0, busy}, 32'd0);
    do_cycle(1'b0, 2'b00, 32'd0, 4'd0, 24'd0);
    check("oob_err_t2",  {31'd0, err},  32'd0);
    check("oob_drdy_t2", {31'd0, drdy}, 32'd0);
`else
    check("oob_err_t1",  {31'd0, err},  32'd0);
    check("oob_drdy_t1", {31'd0, drdy}, 32'd1);
    check("oob_odr_t1",  {8'd0, odr},   {8'd0, 24'hBBBBBB});
    do_cycle(1'b0, 2'b00, 32'd0, 4'd0, 24'd0);
    check("oob_drdy_t2", {31'd0, drdy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
